// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a shared multicycle RV32I datapath.
// Ports: clk, reset (async, active-high); instruction (latched IR), mem_ready, branch_taken in;
//   mem_req/mem_we/mem_addr_src memory port controls, ir_write, pc_write/pc_src,
//   alu_a_src/alu_b_src/alu_mode, reg_write/wb_src datapath controls;
//   trap/fault_code sticky fault status; retired instruction count.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_src,
    output logic        alu_b_src,
    output logic [1:0]  alu_mode,
    output logic        reg_write,
    output logic [1:0]  wb_src,
    output logic        trap,
    output logic [1:0]  fault_code,
    output logic [31:0] retired
);
    localparam logic [2:0] FETCH     = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEM       = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;
    localparam logic [2:0] TRAP      = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [2:0] state, next;
    logic [7:0] wait_cnt;
    logic [6:0] op;
    logic       is_load, is_store, is_jal, is_jalr, legal, timeout;
    logic       unused_bits;

    // funct3/funct7 are decoded by the ALU itself, not by this sequencer
    assign unused_bits = ^instruction[31:7];
    assign op       = instruction[6:0];
    assign is_load  = op == OP_LOAD;
    assign is_store = op == OP_STORE;
    assign is_jal   = op == OP_JAL;
    assign is_jalr  = op == OP_JALR;
    assign legal    = op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JALR};
    // a ready arriving on the limit cycle still completes the request
    assign timeout  = !mem_ready && wait_cnt == LIMIT;

    always_comb begin
        next         = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        alu_a_src    = 2'd0;
        alu_b_src    = 1'b0;
        alu_mode     = 2'd0;
        reg_write    = 1'b0;
        wb_src       = 2'd0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                next     = mem_ready ? DECODE : timeout ? TRAP : FETCH;
            end
            DECODE: begin
                // alu_out captures PC+imm for JAL and branch targets
                alu_a_src = 2'd1;
                alu_b_src = 1'b1;
                next      = is_jal ? WRITEBACK : legal ? EXECUTE : TRAP;
            end
            EXECUTE: begin
                alu_a_src = op == OP_LUI ? 2'd2 : op == OP_AUIPC ? 2'd1 : 2'd0;
                alu_b_src = op != OP_R && op != OP_BRANCH;
                alu_mode  = op == OP_R ? 2'd1 : op == OP_IMM ? 2'd2 : 2'd0;
                if (op == OP_BRANCH) begin
                    alu_b_src = 1'b0;
                    pc_write  = 1'b1;
                    pc_src    = {1'b0, branch_taken};
                end
                next = op == OP_BRANCH ? FETCH : (is_load || is_store) ? MEM : WRITEBACK;
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = is_store;
                pc_write     = is_store && mem_ready;
                next         = mem_ready ? (is_store ? FETCH : WRITEBACK) : timeout ? TRAP : MEM;
            end
            WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                wb_src    = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : 2'd0;
                pc_src    = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
                next      = FETCH;
            end
            TRAP: next = TRAP;
            default: next = FETCH;
        endcase
        // reset must never let a partial strobe reach the datapath
        if (reset) begin
            {mem_req, mem_we, mem_addr_src, ir_write, pc_write, reg_write} = '0;
            {pc_src, alu_a_src, alu_b_src, alu_mode, wb_src} = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            retired    <= '0;
            trap       <= 1'b0;
            fault_code <= 2'd0;
            wait_cnt   <= '0;
        end else begin
            state <= next;
            if (pc_write)
                retired <= retired + 32'd1;
            // any non-waiting cycle (ready, or no request) restarts the count
            wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
            if (next == TRAP && state != TRAP) begin
                trap       <= 1'b1;
                fault_code <= state == DECODE ? 2'd1 : 2'd2;
            end
        end
    end
endmodule
